// File: rtl/bcd_cascade_counter.sv
// Cascaded modulo-LIMIT digit counter stepped by an internal prescaler; clear > load > step.
// count/tick/carry are registered (1-cycle latency from clear/load); no backpressure, free-running.
module bcd_cascade_counter #(
    parameter int PERIOD  = 50000000,
    parameter int DIGITS  = 2,
    parameter int DIGIT_W = 4,
    parameter int LIMIT   = 10
) (
    input  logic                        CLK_50M,
    input  logic                        RESET,
    input  logic                        en,
    input  logic                        up,
    input  logic                        clear,
    input  logic                        load,
    input  logic [DIGITS*DIGIT_W-1:0]   load_value,
    output logic [DIGITS*DIGIT_W-1:0]   count,
    output logic                        tick,
    output logic                        carry
);

    localparam int                 PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int                 CW     = DIGITS * DIGIT_W;
    localparam logic [PW-1:0]      P_LAST = PW'(PERIOD - 1);
    localparam logic [DIGIT_W-1:0] D_MAX  = DIGIT_W'(LIMIT - 1);
    // One extra bit so LIMIT == 2**DIGIT_W is representable.
    localparam logic [DIGIT_W:0]   D_LIM  = (DIGIT_W + 1)'(LIMIT);

    logic [PW-1:0] r_p;
    logic [CW-1:0] r_count;
    logic          r_tick;
    logic          r_carry;

    logic          w_step;
    logic          w_wrap;
    logic [CW-1:0] w_next;
    logic [CW-1:0] w_load;

    assign w_step = en && (r_p == P_LAST);

    // w_lower: every digit below i sits at its rollover value for the current direction.
    always_comb begin : next_count
        logic               w_lower;
        logic [DIGIT_W-1:0] w_d;
        w_next  = r_count;
        w_lower = 1'b1;
        w_d     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_d = r_count[i*DIGIT_W +: DIGIT_W];
            if (w_lower) begin
                if (up)
                    w_next[i*DIGIT_W +: DIGIT_W] = (w_d == D_MAX) ? '0 : w_d + 1'b1;
                else
                    w_next[i*DIGIT_W +: DIGIT_W] = (w_d == '0) ? D_MAX : w_d - 1'b1;
            end
            w_lower = w_lower && (up ? (w_d == D_MAX) : (w_d == '0));
        end
        w_wrap = w_lower;
    end

    always_comb begin : clamp_load
        logic [DIGIT_W-1:0] w_d;
        w_load = load_value;
        w_d    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_d = load_value[i*DIGIT_W +: DIGIT_W];
            if ({1'b0, w_d} >= D_LIM)
                w_load[i*DIGIT_W +: DIGIT_W] = D_MAX;
        end
    end

    always_ff @(posedge CLK_50M or posedge RESET) begin
        if (RESET) begin
            r_p     <= '0;
            r_count <= '0;
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
        end else if (clear) begin
            r_p     <= '0;
            r_count <= '0;
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
        end else if (load) begin
            r_p     <= '0;
            r_count <= w_load;
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            if (en)
                r_p <= (r_p == P_LAST) ? '0 : r_p + 1'b1;
            if (w_step)
                r_count <= w_next;
            r_tick  <= w_step;
            r_carry <= w_step && w_wrap;
        end
    end

    assign count = r_count;
    assign tick  = r_tick;
    assign carry = r_carry;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Directed + randomized bench for bcd_cascade_counter; reference model holds the count as an integer.
module tb_bcd_cascade_counter;

    localparam int PERIOD  = 4;
    localparam int DIGITS  = 2;
    localparam int DIGIT_W = 4;
    localparam int LIMIT   = 10;
    localparam int CW      = DIGITS * DIGIT_W;
    localparam int M       = LIMIT ** DIGITS;

    logic          CLK_50M;
    logic          RESET;
    logic          en;
    logic          up;
    logic          clear;
    logic          load;
    logic [CW-1:0] load_value;
    logic [CW-1:0] count;
    logic          tick;
    logic          carry;

    int n_checks;
    int n_errors;

    // Reference state: count as a plain integer in [0, M), prescaler as enabled-cycle phase.
    int m_n;
    int m_p;
    int m_tick;
    int m_carry;

    bcd_cascade_counter #(
        .PERIOD(PERIOD), .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .LIMIT(LIMIT)
    ) dut (
        .CLK_50M(CLK_50M), .RESET(RESET), .en(en), .up(up), .clear(clear),
        .load(load), .load_value(load_value), .count(count), .tick(tick), .carry(carry)
    );

    initial begin
        CLK_50M = 1'b0;
        forever #5 CLK_50M = ~CLK_50M;
    end

    function automatic logic [CW-1:0] to_packed(input int n);
        logic [CW-1:0] v;
        int            r;
        v = '0;
        r = n;
        for (int i = 0; i < DIGITS; i++) begin
            v[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(r % LIMIT);
            r = r / LIMIT;
        end
        return v;
    endfunction

    function automatic int from_packed_clamped(input logic [CW-1:0] v);
        int n;
        int w;
        int d;
        n = 0;
        w = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(v[i*DIGIT_W +: DIGIT_W]);
            if (d > LIMIT - 1) d = LIMIT - 1;
            n = n + d * w;
            w = w * LIMIT;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_p = 0; m_tick = 0; m_carry = 0;
    endtask

    task automatic model_edge();
        int step;
        int wrap;
        if (clear) begin
            m_n = 0; m_p = 0; m_tick = 0; m_carry = 0;
        end else if (load) begin
            m_n = from_packed_clamped(load_value); m_p = 0; m_tick = 0; m_carry = 0;
        end else begin
            step = (en && m_p == PERIOD - 1) ? 1 : 0;
            wrap = up ? (m_n == M - 1) : (m_n == 0);
            if (en) m_p = (m_p + 1) % PERIOD;
            if (step != 0) m_n = up ? (m_n + 1) % M : (m_n + M - 1) % M;
            m_tick  = step;
            m_carry = (step != 0 && wrap != 0) ? 1 : 0;
        end
    endtask

    // Advance one edge and compare all outputs with the model.
    task automatic run_edge(input string tag);
        model_edge();
        @(posedge CLK_50M);
        #1;
        check({tag, ".count"}, 32'(count), 32'(to_packed(m_n)));
        check({tag, ".tick"},  32'(tick),  32'(m_tick));
        check({tag, ".carry"}, 32'(carry), 32'(m_carry));
    endtask

    task automatic run_edges(input string tag, input int n);
        for (int i = 0; i < n; i++) run_edge(tag);
    endtask

    task automatic do_load(input logic [CW-1:0] v);
        load = 1'b1; load_value = v;
        run_edge("load");
        load = 1'b0;
    endtask

    task automatic async_reset_pulse(input string tag);
        #3 RESET = 1'b1;
        #1;
        check({tag, ".count"}, 32'(count), 32'h0);
        check({tag, ".tick"},  32'(tick),  32'h0);
        check({tag, ".carry"}, 32'(carry), 32'h0);
        #1 RESET = 1'b0;
        model_reset();
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        RESET = 1'b1; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_value = '0;
        model_reset();
        #1;
        check("reset.count", 32'(count), 32'h0);
        check("reset.tick",  32'(tick),  32'h0);
        check("reset.carry", 32'(carry), 32'h0);
        @(posedge CLK_50M); @(posedge CLK_50M); #1;
        RESET = 1'b0;

        // Up count from reset
        en = 1'b1; up = 1'b1;
        run_edges("up", 4);
        check("up4.count", 32'(count), 32'h01);
        check("up4.tick",  32'(tick),  32'h1);
        run_edges("up", 32);
        check("up36.count", 32'(count), 32'h09);
        run_edges("up", 4);
        check("up40.count", 32'(count), 32'h10);

        // Full wrap up
        do_load(8'h99);
        run_edges("wrapup", 4);
        check("wrapup.count", 32'(count), 32'h00);
        check("wrapup.carry", 32'(carry), 32'h1);
        check("wrapup.tick",  32'(tick),  32'h1);
        run_edge("wrapup_after");
        check("wrapup_after.carry", 32'(carry), 32'h0);

        // Down count
        up = 1'b0;
        do_load(8'h10);
        run_edges("down", 4);
        check("down10.count", 32'(count), 32'h09);
        check("down10.carry", 32'(carry), 32'h0);
        do_load(8'h00);
        run_edges("down", 4);
        check("down00.count", 32'(count), 32'h99);
        check("down00.carry", 32'(carry), 32'h1);

        // clear + load on a stepping edge
        up = 1'b1;
        do_load(8'h00);
        run_edges("pre", 3);
        clear = 1'b1; load = 1'b1; load_value = 8'h55;
        run_edge("clrld");
        clear = 1'b0; load = 1'b0;
        check("clrld.count", 32'(count), 32'h00);
        check("clrld.tick",  32'(tick),  32'h0);

        do_load(8'hAF);
        check("clamp.count", 32'(count), 32'h99);

        run_edges("pre2", 3);
        do_load(8'h42);
        check("ldstep.count", 32'(count), 32'h42);
        check("ldstep.tick",  32'(tick),  32'h0);

        // Enable hold mid-period
        run_edges("hold_pre", 2);
        en = 1'b0;
        run_edges("hold", 10);
        check("hold.count", 32'(count), 32'h42);
        en = 1'b1;
        run_edge("resume1");
        check("resume1.tick", 32'(tick), 32'h0);
        run_edge("resume2");
        check("resume2.tick",  32'(tick),  32'h1);
        check("resume2.count", 32'(count), 32'h43);

        // Async reset mid-period and with a tick/carry in flight
        do_load(8'h37);
        run_edges("mid", 2);
        async_reset_pulse("arst_mid");
        run_edges("post_arst", 5);
        do_load(8'h99);
        run_edges("inflight", 4);
        check("inflight.carry", 32'(carry), 32'h1);
        async_reset_pulse("arst_inflight");
        run_edges("post_arst2", 3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en    = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 49) == 0) up = ~up;
            clear = ($urandom_range(0, 59) == 0);
            load  = ($urandom_range(0, 29) == 0);
            load_value = CW'($urandom);
            run_edge("rand");
        end
        clear = 1'b0; load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_cascade_counter.md
# bcd_cascade_counter

Parametrised multi-digit cascaded counter with a built-in prescaler, the successor to the fixed two-digit divider-plus-counter LED demo. It replaces the derived-clock style with a single clock and a one-cycle step enable. It generalises digit count, digit width and per-digit modulus, and adds up/down mode, enable, synchronous clear, parallel load and a wrap carry. It sits directly under the board top, driving LED or 7-segment buses from CLK_50M.

## Interface
- PERIOD, 50000000: clock cycles per count step; legal range ≥1.
- DIGITS, 2: number of cascaded digits; legal range ≥1.
- DIGIT_W, 4: bits per digit.
- LIMIT, 10: modulus of every digit; legal range 2 ≤ LIMIT ≤ 2^DIGIT_W.
- CLK_50M  in  1  single system clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- en  in  1  prescaler/count enable.
- up  in  1  1 = count up, 0 = count down.
- clear  in  1  synchronous clear.
- load  in  1  synchronous parallel load.
- load_value  in  DIGITS*DIGIT_W  value to load; digit i in bits [i*DIGIT_W +: DIGIT_W]; digit 0 is least significant.
- count  out  DIGITS*DIGIT_W  current count; same digit packing as load_value.
- tick  out  1  one-cycle pulse on every step.
- carry  out  1  one-cycle pulse on full wrap.

## Operation
- Prescaler p: width $clog2(PERIOD), minimum 1 bit.
  - Resets to 0.
  - When en=1, increments each cycle, and wraps from PERIOD-1 to 0.
  - When en=0, holds.
  - Internal step = en && (p == PERIOD-1). With PERIOD=1, step = en.
- Priority per edge, highest first: clear, load, step.
  - clear: p, count, tick, carry all go to 0. Applies regardless of en.
  - load: count ← load_value and p ← 0. Each digit ≥ LIMIT is clamped to LIMIT-1. tick and carry go to 0.
  - step, up=1:
    - Digit 0 increments.
    - Digit i>0 increments only when all lower digits equal LIMIT-1.
    - A digit at LIMIT-1 that increments wraps to 0.
  - step, up=0:
    - Digit 0 decrements.
    - Digit i>0 decrements only when all lower digits equal 0.
    - A digit at 0 that decrements wraps to LIMIT-1.
- Full wrap:
  - Up: all digits go from LIMIT-1 to 0.
  - Down: all digits go from 0 to LIMIT-1.
- tick ← step, registered. It is high for exactly the cycle following each stepping edge.
- carry ← step && full wrap, registered. It is high only in the cycle in which tick is high.
- A change of up takes effect at the next step. It does not reset p.
- Arithmetic is per digit and modulo LIMIT. There is no binary overflow between digits.

## Timing
- RESET assertion immediately forces, with no clock edge: p=0, count=0, tick=0, carry=0.
- RESET deassertion: counting begins on the first rising edge with en=1. The first step occurs on the PERIOD-th enabled edge.
- The stepping edge updates count, and asserts tick (and carry on full wrap), at the same time. Both pulses last one cycle.
- clear and load take effect on the next edge. Their latency to count is 1 cycle.
- After load, the first step occurs PERIOD enabled edges later.
- en low mid-period freezes p. Resuming continues from the remaining cycles and does not restart the period.
- clear and load together: clear wins.
- load and step together: load wins, and that step is discarded (no tick).
- RESET mid-count aborts everything, including an in-flight tick or carry.

## Test plan
- Async reset: with count=0x37 and p mid-period, pulse RESET between clock edges → count=0x00, tick=0 and carry=0 before the next edge.
- Up count (PERIOD=4, DIGITS=2, LIMIT=10), en=1 and up=1 from reset:
  - After 4 edges, count=0x01 and tick is high 1 cycle.
  - After 36 edges, count=0x09.
  - After 40 edges, count=0x10.
  - tick is high on every 4th cycle only.
- Full wrap up: load 0x99, then 4 enabled edges → count=0x00, with carry=1 and tick=1 for one cycle.
- Down count:
  - Load 0x10, up=0, 4 edges → count=0x09 and carry=0.
  - Load 0x00, 4 edges → count=0x99 and carry=1.
- Priority and clamp:
  - Assert clear and load together on the stepping edge → count=0x00, tick=0.
  - load 0xAF → count=0x99.
  - load on a stepping edge → count=load_value, no tick.
- Enable hold: drop en after 2 of 4 prescaler cycles for 10 cycles → count and p unchanged. After re-enable, step occurs on the 2nd edge.
